intersection_control: RTL and testbench

//  Parametrised N-approach traffic-light controller; successor of the single-approach control block.

---
 rtl/traffic_pkg.sv | 39 +++
 rtl/interval_timer.sv | 45 ++++
 rtl/intersection_control.sv | 208 ++++++++++++++++++++
 tb/tb_intersection_control.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and helpers for the intersection controller and its benches.
package traffic_pkg;

   // Two-bit lamp drive code per approach
   typedef enum logic [1:0] {
      OFF    = 2'b00,
      RED    = 2'b01,
      YELLOW = 2'b10,
      GREEN  = 2'b11
   } light_t;

   // Controller phases
   typedef enum logic [2:0] {
      S_GREEN,
      S_YELLOW,
      S_ALLRED,
      S_WALK,
      S_FLASH
   } state_t;

   // Largest of the phase interval lengths, used to size the interval timer
   function automatic int unsigned max_interval(input int unsigned a, input int unsigned b,
                                                input int unsigned c, input int unsigned d,
                                                input int unsigned e);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      if (e > m) m = e;
      return m;
   endfunction

   // Index width that never collapses to zero bits
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/interval_timer.sv
// Tick detector plus restartable tick counter. done_o pulses on the tick that
// completes an interval of len_i ticks; the owner restarts it on every phase change.
module interval_timer #(
   parameter int unsigned C_WIDTH = 3
) (
   input  logic               clk,
   input  logic               rstb,
   input  logic               blink_i,
   input  logic               restart_i,
   input  logic [C_WIDTH-1:0] len_i,
   output logic               done_o
);

   logic               blink_q;
   logic               tick;
   logic [C_WIDTH-1:0] cnt_q;
   logic [C_WIDTH-1:0] cnt_d;
   logic [C_WIDTH:0]   cnt_inc;

   assign tick    = blink_i & ~blink_q;
   assign cnt_inc = {1'b0, cnt_q} + (C_WIDTH + 1)'(1);
   assign done_o  = tick && (cnt_inc == {1'b0, len_i});

   // Next count: restart wins over a coincident tick
   always_comb begin
      cnt_d = cnt_q;
      if (restart_i) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = cnt_inc[C_WIDTH-1:0];
      end
   end

   // Blink history and tick counter
   always_ff @(posedge clk) begin
      if (!rstb) begin
         blink_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         blink_q <= blink_i;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/intersection_control.sv
// N-approach traffic-light controller: round-robin green with traffic-actuated
// extension, latched pedestrian requests served in an all-red walk phase, and a
// flashing-yellow override. All outputs are registered from the next-state values.
module intersection_control
   import traffic_pkg::*;
#(
   parameter int unsigned C_APPROACHES = 4,
   parameter int unsigned C_INT_GREEN  = 6,
   parameter int unsigned C_INT_YELLOW = 2,
   parameter int unsigned C_INT_RED    = 4,
   parameter int unsigned C_INT_WALK   = 4,
   parameter int unsigned C_INT_EXT    = 2,
   parameter int unsigned C_MAX_EXT    = 2,
   localparam int unsigned C_IW = clog2_min1(C_APPROACHES)
) (
   input  logic                      clk,
   input  logic                      rstb,
   input  logic                      blink,
   input  logic                      inMode,
   input  logic [C_APPROACHES-1:0]   inTraffic,
   input  logic [C_APPROACHES-1:0]   inPedestrian,
   output logic [2*C_APPROACHES-1:0] outLight,
   output logic [C_APPROACHES-1:0]   outWalk,
   output logic [C_IW-1:0]           outActive
);

   localparam int unsigned N    = C_APPROACHES;
   localparam int unsigned C_TW = $clog2(max_interval(C_INT_GREEN, C_INT_YELLOW, C_INT_RED,
                                                      C_INT_WALK, C_INT_EXT) + 1);
   localparam int unsigned C_EW = clog2_min1(C_MAX_EXT + 1);

   localparam logic [C_EW-1:0]  C_EXT_LIM = C_EW'(C_MAX_EXT);
   localparam logic [C_IW-1:0]  C_LAST    = C_IW'(N - 1);
   localparam logic [2*N-1:0]   C_ALL_RED = {N{RED}};

   state_t            state_q, state_d;
   logic [C_IW-1:0]   active_q, active_d;
   logic [C_EW-1:0]   ext_q, ext_d;
   logic [N-1:0]      pend_q, pend_d;
   logic [N-1:0]      snap_q, snap_d;
   logic [2*N-1:0]    light_q, light_d;
   logic [N-1:0]      walk_q, walk_d;

   logic [C_TW-1:0]   len;
   logic              done;
   logic              restart;
   logic              ext_restart;

   logic [C_IW-1:0]   next_green;
   logic              ng_found;
   logic [C_IW:0]     ng_sum;

   interval_timer #(
      .C_WIDTH (C_TW)
   ) u_timer (
      .clk       (clk),
      .rstb      (rstb),
      .blink_i   (blink),
      .restart_i (restart),
      .len_i     (len),
      .done_o    (done)
   );

   // Any phase change, an extension, or sitting in FLASH holds the timer at zero
   assign restart = (state_d != state_q) || (state_d == S_FLASH) || ext_restart;

   // Interval length of the current phase
   always_comb begin
      len = C_TW'(C_INT_RED);
      unique case (state_q)
         S_GREEN:  len = (ext_q == '0) ? C_TW'(C_INT_GREEN) : C_TW'(C_INT_EXT);
         S_YELLOW: len = C_TW'(C_INT_YELLOW);
         S_ALLRED: len = C_TW'(C_INT_RED);
         S_WALK:   len = C_TW'(C_INT_WALK);
         S_FLASH:  len = C_TW'(C_INT_RED);
         default:  len = C_TW'(C_INT_RED);
      endcase
   end

   // Round-robin search for the first requesting approach after the current owner
   always_comb begin
      next_green = (active_q == C_LAST) ? '0 : active_q + C_IW'(1);
      ng_found   = 1'b0;
      ng_sum     = '0;
      for (int k = 1; k <= int'(N); k++) begin
         ng_sum = {1'b0, active_q} + (C_IW + 1)'(k);
         if (ng_sum >= (C_IW + 1)'(N)) begin
            ng_sum = ng_sum - (C_IW + 1)'(N);
         end
         if (!ng_found && inTraffic[ng_sum[C_IW-1:0]]) begin
            ng_found   = 1'b1;
            next_green = ng_sum[C_IW-1:0];
         end
      end
   end

   // State register: phase, owner, extension count, pending requests, outputs
   always_ff @(posedge clk) begin
      if (!rstb) begin
         state_q  <= S_ALLRED;
         active_q <= C_LAST;
         ext_q    <= '0;
         pend_q   <= '0;
         snap_q   <= '0;
         light_q  <= C_ALL_RED;
         walk_q   <= '0;
      end else begin
         state_q  <= state_d;
         active_q <= active_d;
         ext_q    <= ext_d;
         pend_q   <= pend_d;
         snap_q   <= snap_d;
         light_q  <= light_d;
         walk_q   <= walk_d;
      end
   end

   // Next-state logic: mode override first, then interval expiry per phase
   always_comb begin
      state_d     = state_q;
      active_d    = active_q;
      ext_d       = ext_q;
      snap_d      = snap_q;
      ext_restart = 1'b0;

      // Served requests drop at walk exit; a new request in the same cycle survives
      pend_d = pend_q;
      if ((state_q == S_WALK) && done) begin
         pend_d = pend_d & ~snap_q;
      end
      if (state_q != S_FLASH) begin
         pend_d = pend_d | inPedestrian;
      end

      if (inMode) begin
         state_d = S_FLASH;
         ext_d   = '0;
         pend_d  = '0;
      end else begin
         unique case (state_q)
            S_GREEN: begin
               if (done) begin
                  if (inTraffic[active_q] && (ext_q != C_EXT_LIM)) begin
                     ext_d       = ext_q + C_EW'(1);
                     ext_restart = 1'b1;
                  end else begin
                     state_d = S_YELLOW;
                  end
               end
            end
            S_YELLOW: begin
               if (done) state_d = S_ALLRED;
            end
            S_ALLRED: begin
               if (done) begin
                  if (|pend_d) begin
                     state_d = S_WALK;
                     snap_d  = pend_d;
                  end else begin
                     state_d  = S_GREEN;
                     active_d = next_green;
                     ext_d    = '0;
                  end
               end
            end
            S_WALK: begin
               if (done) begin
                  state_d  = S_GREEN;
                  active_d = next_green;
                  ext_d    = '0;
                  snap_d   = '0;
               end
            end
            S_FLASH: begin
               state_d = S_ALLRED;
            end
            default: begin
               state_d = S_ALLRED;
            end
         endcase
      end
   end

   // Output decode from the next state so lamps change on the same edge as the phase
   always_comb begin
      light_d = C_ALL_RED;
      walk_d  = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (state_d == S_FLASH) begin
            light_d[2*i +: 2] = blink ? YELLOW : OFF;
         end else if (C_IW'(i) == active_d) begin
            if (state_d == S_GREEN) begin
               light_d[2*i +: 2] = GREEN;
            end else if (state_d == S_YELLOW) begin
               light_d[2*i +: 2] = YELLOW;
            end
         end
      end
      if (state_d == S_WALK) begin
         walk_d = snap_d;
      end
   end

   assign outLight  = light_q;
   assign outWalk   = walk_q;
   assign outActive = active_q;

endmodule

// File: tb/tb_intersection_control.sv
// Bench for intersection_control (N=4, default intervals). A phase/countdown
// reference model runs alongside the DUT; each scenario task checks its own points.
module tb_intersection_control;
   import traffic_pkg::*;

   localparam int N    = 4;
   localparam int T_G  = 6;
   localparam int T_Y  = 2;
   localparam int T_R  = 4;
   localparam int T_W  = 4;
   localparam int T_E  = 2;
   localparam int MAXE = 2;

   logic           clk          = 1'b0;
   logic           rstb         = 1'b0;
   logic           blink        = 1'b0;
   logic           inMode       = 1'b0;
   logic [N-1:0]   inTraffic    = '0;
   logic [N-1:0]   inPedestrian = '0;
   logic [2*N-1:0] outLight;
   logic [N-1:0]   outWalk;
   logic [1:0]     outActive;

   int checks = 0;
   int errors = 0;
   int half_left = 3;

   // Reference model: phase, ticks remaining, extensions used, owner, requests
   state_t         m_st;
   int             m_left, m_ext, m_active;
   logic [N-1:0]   m_pend, m_snap, m_walk;
   logic [2*N-1:0] m_light;
   logic           m_pb, m_tick;

   intersection_control #(
      .C_APPROACHES (N),
      .C_INT_GREEN  (T_G),
      .C_INT_YELLOW (T_Y),
      .C_INT_RED    (T_R),
      .C_INT_WALK   (T_W),
      .C_INT_EXT    (T_E),
      .C_MAX_EXT    (MAXE)
   ) dut (
      .clk          (clk),
      .rstb         (rstb),
      .blink        (blink),
      .inMode       (inMode),
      .inTraffic    (inTraffic),
      .inPedestrian (inPedestrian),
      .outLight     (outLight),
      .outWalk      (outWalk),
      .outActive    (outActive)
   );

   always #5 clk = ~clk;

   task automatic model_green();
      int  c;
      bit  found;
      found = 0;
      c = (m_active + 1) % N;
      for (int k = 1; k <= N; k++) begin
         if (!found && inTraffic[(m_active + k) % N]) begin
            found = 1;
            c = (m_active + k) % N;
         end
      end
      m_active = c;
      m_ext    = 0;
      m_st     = S_GREEN;
      m_left   = T_G;
   endtask

   task automatic model_step();
      logic [N-1:0] np;
      bit           ends;
      if (!rstb) begin
         m_st = S_ALLRED; m_left = T_R; m_ext = 0; m_active = N - 1;
         m_pend = '0; m_snap = '0; m_pb = 1'b0; m_tick = 1'b0;
      end else begin
         m_tick = blink && !m_pb;
         m_pb   = blink;
         ends   = (m_st != S_FLASH) && m_tick && (m_left == 1);
         np = m_pend;
         if (m_st == S_WALK && ends) np = np & ~m_snap;
         if (m_st != S_FLASH) np = np | inPedestrian;
         if (inMode) begin
            m_st = S_FLASH; m_ext = 0; np = '0;
         end else if (m_st == S_FLASH) begin
            m_st = S_ALLRED; m_left = T_R;
         end else if (!ends) begin
            if (m_tick) m_left--;
         end else begin
            case (m_st)
               S_GREEN:
                  if (inTraffic[m_active] && m_ext < MAXE) begin
                     m_ext++; m_left = T_E;
                  end else begin
                     m_st = S_YELLOW; m_left = T_Y;
                  end
               S_YELLOW: begin m_st = S_ALLRED; m_left = T_R; end
               S_ALLRED:
                  if (np != 0) begin
                     m_st = S_WALK; m_snap = np; m_left = T_W;
                  end else begin
                     model_green();
                  end
               default: model_green();
            endcase
         end
         m_pend = np;
      end
      for (int i = 0; i < N; i++) begin
         if (m_st == S_FLASH)                       m_light[2*i +: 2] = blink ? 2'b10 : 2'b00;
         else if (i == m_active && m_st == S_GREEN)  m_light[2*i +: 2] = 2'b11;
         else if (i == m_active && m_st == S_YELLOW) m_light[2*i +: 2] = 2'b10;
         else                                        m_light[2*i +: 2] = 2'b01;
      end
      m_walk = (m_st == S_WALK) ? m_snap : '0;
   endtask

   // One clock: model follows the edge, outputs settle, blink advances away from the edge
   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      half_left--;
      if (half_left == 0) begin
         blink = ~blink;
         half_left = $urandom_range(2, 4);
      end
   endtask

   // 1 green, 2 yellow, 3 all red, 4 walk (meaningful outside flash)
   function automatic int dut_phase();
      if (outWalk != 0) return 4;
      for (int i = 0; i < N; i++) begin
         if (outLight[2*i +: 2] == 2'b11) return 1;
         if (outLight[2*i +: 2] == 2'b10) return 2;
      end
      return 3;
   endfunction

   task automatic test_reset();
      int ticks;
      rstb = 1'b0;
      repeat (20) step();
      checks++;
      if (outLight !== 8'b01010101) begin
         errors++; $display("FAIL reset_light: got %b want 01010101", outLight);
      end
      checks++;
      if (outWalk !== 4'b0000) begin
         errors++; $display("FAIL reset_walk: got %b want 0000", outWalk);
      end
      checks++;
      if (outActive !== 2'd3) begin
         errors++; $display("FAIL reset_active: got %0d want 3", outActive);
      end
      rstb  = 1'b1;
      ticks = 0;
      for (int c = 0; c < 300; c++) begin
         step();
         if (m_tick) ticks++;
         if (outLight[1:0] == 2'b11) break;
      end
      checks++;
      if (outLight !== 8'b01010111 || outActive !== 2'd0 || ticks != 4) begin
         errors++;
         $display("FAIL reset_first_green: light=%b active=%0d ticks=%0d want 01010111 0 4",
                  outLight, outActive, ticks);
      end
   endtask

   task automatic test_rotation();
      int seq[$];
      int prev_ph, ph, dur, segs;
      logic [1:0] last_act;
      inTraffic = '0; inPedestrian = '0;
      last_act = outActive; prev_ph = dut_phase(); dur = 0; segs = 0;
      for (int c = 0; c < 2000 && seq.size() < 4; c++) begin
         step();
         if (prev_ph == dut_phase() || 1) if (m_tick) dur++;
         checks++;
         if (outLight !== m_light || outWalk !== m_walk || outActive !== 2'(m_active)) begin
            errors++;
            $display("FAIL rotation_model: light=%b walk=%b act=%0d want %b %b %0d",
                     outLight, outWalk, outActive, m_light, m_walk, m_active);
         end
         ph = dut_phase();
         if (ph != prev_ph) begin
            checks++;
            if ((prev_ph == 1 && dur != T_G) || (prev_ph == 2 && dur != T_Y) ||
                (prev_ph == 3 && dur != T_R) || prev_ph == 4) begin
               errors++;
               $display("FAIL rotation_duration: phase %0d lasted %0d ticks", prev_ph, dur);
            end
            dur = 0; prev_ph = ph;
         end
         if (outActive != last_act) begin
            seq.push_back(int'(outActive));
            last_act = outActive;
         end
      end
      checks++;
      if (seq.size() != 4 || seq[0] != 1 || seq[1] != 2 || seq[2] != 3 || seq[3] != 0) begin
         errors++; $display("FAIL rotation_order: got %p want 1 2 3 0", seq);
      end
   endtask

   task automatic test_extension();
      int  ticks;
      bit  seen;
      logic [1:0] pre;
      inTraffic = 4'b0010;
      seen = 0;
      for (int c = 0; c < 1500 && !seen; c++) begin
         step();
         if (outLight[3:2] == 2'b11) seen = 1;
      end
      ticks = 0;
      for (int c = 0; c < 1500 && seen; c++) begin
         pre = outLight[3:2];
         step();
         checks++;
         if (outLight !== m_light || outActive !== 2'(m_active)) begin
            errors++;
            $display("FAIL extension_model: light=%b act=%0d want %b %0d",
                     outLight, outActive, m_light, m_active);
         end
         if (pre == 2'b11 && m_tick) ticks++;
         if (outLight[3:2] != 2'b11) break;
      end
      checks++;
      if (!seen || ticks != T_G + 2 * T_E || outLight[3:2] !== 2'b10 || outActive !== 2'd1) begin
         errors++;
         $display("FAIL extension_length: green ticks=%0d light1=%b act=%0d want 10 10 1",
                  ticks, outLight[3:2], outActive);
      end
      inTraffic = '0;
   endtask

   task automatic test_skip();
      bit seen;
      seen = 0;
      for (int c = 0; c < 2500 && !seen; c++) begin
         step();
         if (outLight[1:0] == 2'b11) seen = 1;
      end
      inTraffic = 4'b1000;
      for (int c = 0; c < 1500 && seen; c++) begin
         step();
         if (outActive != 2'd0) break;
      end
      checks++;
      if (!seen || outActive !== 2'd3 || outLight !== 8'b11010101) begin
         errors++;
         $display("FAIL skip_to_3: act=%0d light=%b want 3 11010101", outActive, outLight);
      end
      inTraffic = '0;
   endtask

   task automatic test_pedestrian();
      int prev, ticks, walk_seen;
      bit got;
      logic [1:0] act0;
      repeat (3) step();
      inPedestrian = 4'b0100;
      step();
      inPedestrian = '0;
      got = 0; prev = dut_phase();
      for (int c = 0; c < 1500; c++) begin
         prev = dut_phase();
         step();
         if (outWalk != 0) begin got = 1; break; end
      end
      checks++;
      if (!got || prev != 3 || outWalk !== 4'b0100 || outLight !== 8'b01010101) begin
         errors++;
         $display("FAIL ped_walk: walk=%b light=%b prev=%0d want 0100 01010101 3",
                  outWalk, outLight, prev);
      end
      ticks = 0;
      for (int c = 0; c < 500 && got; c++) begin
         step();
         if (m_tick) ticks++;
         if (outWalk == 0) break;
      end
      checks++;
      if (ticks != T_W || dut_phase() != 1 || outWalk !== 4'b0000) begin
         errors++;
         $display("FAIL ped_walk_len: ticks=%0d phase=%0d want 4 1", ticks, dut_phase());
      end
      act0 = outActive; walk_seen = 0;
      for (int c = 0; c < 1500; c++) begin
         step();
         if (outWalk != 0) walk_seen++;
         if (outActive != act0) break;
      end
      checks++;
      if (walk_seen != 0 || outActive === act0) begin
         errors++;
         $display("FAIL ped_cleared: walk cycles=%0d act=%0d want 0, new green",
                  walk_seen, outActive);
      end
   endtask

   task automatic test_flash();
      logic b;
      logic [1:0] held;
      int ticks;
      logic [7:0] want;
      repeat (5) step();
      held = outActive;
      inMode = 1'b1;
      for (int c = 0; c < 40; c++) begin
         inPedestrian = N'($urandom);
         b = blink;
         step();
         want = b ? 8'hAA : 8'h00;
         checks++;
         if (outLight !== want || outWalk !== 4'b0000 || outActive !== held) begin
            errors++;
            $display("FAIL flash: light=%b walk=%b act=%0d want %b 0000 %0d",
                     outLight, outWalk, outActive, want, held);
         end
      end
      inPedestrian = '0;
      inMode = 1'b0;
      step();
      checks++;
      if (outLight !== 8'b01010101) begin
         errors++; $display("FAIL flash_exit: light=%b want 01010101", outLight);
      end
      ticks = 0;
      for (int c = 0; c < 500; c++) begin
         step();
         if (m_tick) ticks++;
         if (dut_phase() != 3) break;
      end
      checks++;
      if (ticks != T_R || dut_phase() != 1 || outActive !== 2'(held + 2'd1)) begin
         errors++;
         $display("FAIL flash_resume: ticks=%0d phase=%0d act=%0d want 4 1 %0d",
                  ticks, dut_phase(), outActive, 2'(held + 2'd1));
      end
   endtask

   task automatic test_random();
      int mode_left, nonred;
      mode_left = 0;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 19) == 0) inTraffic = N'($urandom);
         inPedestrian = ($urandom_range(0, 39) == 0) ? N'($urandom) : '0;
         if (mode_left > 0) mode_left--;
         else if ($urandom_range(0, 499) == 0) mode_left = $urandom_range(5, 60);
         inMode = (mode_left > 0);
         rstb = ($urandom_range(0, 1499) != 0);
         step();
         checks++;
         if (outLight !== m_light || outWalk !== m_walk || outActive !== 2'(m_active)) begin
            errors++;
            $display("FAIL random_model: cyc=%0d light=%b walk=%b act=%0d want %b %b %0d",
                     c, outLight, outWalk, outActive, m_light, m_walk, m_active);
         end
         nonred = 0;
         for (int i = 0; i < N; i++) if (outLight[2*i +: 2] != 2'b01) nonred++;
         if (m_st != S_FLASH) begin
            checks++;
            if (nonred > 1 || (outWalk != 0 && m_st != S_WALK)) begin
               errors++;
               $display("FAIL random_invariant: cyc=%0d light=%b walk=%b", c, outLight, outWalk);
            end
         end
      end
      rstb = 1'b1; inMode = 1'b0; inPedestrian = '0; inTraffic = '0;
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_extension();
      test_skip();
      test_pedestrian();
      test_flash();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
